// File: rtl/fifo_packet_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_packet_tx_if
// Read port between the byte FIFO and fifo_packet_tx.
//
// Signals:
//   fifo_data_in  FIFO read data (8 bits)
//   fifo_empty    FIFO holds no bytes
//   fifo_busy     FIFO port busy; no read may be issued
//   fifo_re       one-cycle read request from the consumer
//
// Handshake: fifo_re may only be high in a cycle where fifo_empty and
// fifo_busy were both low at the edge that raised it. It is never high for
// two consecutive cycles. The FIFO updates fifo_data_in on the clock edge
// that samples fifo_re high, so the byte is valid one cycle after the read
// pulse and stays valid until the next read.
//
// Modports:
//   master  the consumer (fifo_packet_tx): drives fifo_re
//   slave   the FIFO: drives data, empty and busy
// ---------------------------------------------------------------------------
interface fifo_packet_tx_if;
   logic [7:0] fifo_data_in;
   logic       fifo_empty;
   logic       fifo_busy;
   logic       fifo_re;

   modport master (
      output fifo_re,
      input  fifo_data_in,
      input  fifo_empty,
      input  fifo_busy
   );

   modport slave (
      input  fifo_re,
      output fifo_data_in,
      output fifo_empty,
      output fifo_busy
   );
endinterface

// File: rtl/fifo_packet_tx.sv
// ---------------------------------------------------------------------------
// fifo_packet_tx
// Pops PKT_LEN bytes from a byte FIFO, sends each as an async frame
// (start 0, 8 data bits MSB-first, stop 1, BAUD_DIV clocks per bit) on tx,
// then appends a CRC-8 frame (poly 0x07, init 0, MSB-first) computed over
// the transmitted data bits. isFinish pulses once per completed packet.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     allows a new packet to start (sampled in IDLE)
//   clear_err  synchronous clear of error (a same-cycle error event wins)
//   fifo       FIFO read port (master side of fifo_packet_tx_if)
//   tx         registered serial line, idles high
//   busy       high whenever the FSM is not in IDLE
//   isFinish   one-cycle pulse after the CRC stop bit
//   CRC        running CRC; holds the final value after a packet
//   error      sticky: [0] underrun timeout, [1] enable dropped mid-packet
//   state_dbg  current FSM state encoding
// ---------------------------------------------------------------------------
module fifo_packet_tx #(
   parameter int PKT_LEN  = 4,
   parameter int BAUD_DIV = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear_err,
   fifo_packet_tx_if.master   fifo,
   output logic               tx,
   output logic               busy,
   output logic               isFinish,
   output logic [7:0]         CRC,
   output logic [3:0]         error,
   output logic [3:0]         state_dbg
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    PKT_BYTES = 8'(PKT_LEN);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FETCH = 4'd1,
      S_WAIT  = 4'd2,
      S_LOAD  = 4'd3,
      S_START = 4'd4,
      S_DATA  = 4'd5,
      S_STOP  = 4'd6,
      S_CRCLD = 4'd7,
      S_DONE  = 4'd8
   } state_t;

   state_t        state;
   logic [7:0]    shift;
   logic [7:0]    byte_cnt;
   logic [2:0]    bit_cnt;
   logic [BW-1:0] baud_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          crc_phase;   // set while the CRC byte itself is on the line

   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   // tx is produced from the state of the previous cycle, so every bit is
   // on the line for exactly BAUD_DIV clocks, one clock behind the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         tx           <= 1'b1;
         fifo.fifo_re <= 1'b0;
         isFinish     <= 1'b0;
         CRC          <= 8'h00;
         error        <= 4'b0000;
         shift        <= 8'h00;
         byte_cnt     <= 8'h00;
         bit_cnt      <= 3'd0;
         baud_cnt     <= '0;
         tmo_cnt      <= '0;
         crc_phase    <= 1'b0;
      end else begin
         tx           <= 1'b1;
         fifo.fifo_re <= 1'b0;
         isFinish     <= 1'b0;

         // Clear first so that an error event later in this block wins.
         if (clear_err) error <= 4'b0000;
         if (state != S_IDLE && !enable) error[1] <= 1'b1;

         case (state)
            S_IDLE: begin
               if (enable && !fifo.fifo_empty) begin
                  CRC       <= 8'h00;
                  byte_cnt  <= 8'h00;
                  tmo_cnt   <= '0;
                  crc_phase <= 1'b0;
                  state     <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (!fifo.fifo_empty && !fifo.fifo_busy) begin
                  fifo.fifo_re <= 1'b1;
                  state        <= S_WAIT;
               end else if (tmo_cnt == TMO_LAST && byte_cnt != 8'h00) begin
                  error[0] <= 1'b1;
                  state    <= S_IDLE;
               end else if (tmo_cnt != TMO_LAST) begin
                  // Saturates while waiting for the very first byte.
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_WAIT: begin
               state <= S_LOAD;
            end

            S_LOAD: begin
               shift    <= fifo.fifo_data_in;
               baud_cnt <= '0;
               state    <= S_START;
            end

            S_START: begin
               tx <= 1'b0;
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= 3'd0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               tx <= shift[7];
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  shift    <= {shift[6:0], 1'b0};
                  if (!crc_phase) begin
                     CRC <= {CRC[6:0], 1'b0} ^ ((CRC[7] ^ shift[7]) ? 8'h07 : 8'h00);
                  end
                  if (bit_cnt == 3'd7) begin
                     state <= S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (crc_phase) begin
                     isFinish <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     tmo_cnt  <= '0;
                     if (byte_cnt + 8'd1 == PKT_BYTES) begin
                        state <= S_CRCLD;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_CRCLD: begin
               shift     <= CRC;
               crc_phase <= 1'b1;
               baud_cnt  <= '0;
               state     <= S_START;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_packet_tx.md
Name: fifo_packet_tx

Overview:
Downstream consumer of the byte FIFO that the parallel-to-FIFO CRC stage writes into. It pops PKT_LEN bytes, serialises each as an async frame on `tx`, then appends a CRC-8 byte computed inline over the transmitted data bits. It pulses `isFinish` per packet and reports sticky errors. It sits between the FIFO and the board's serial output pin.

Parameters:
- PKT_LEN, 4, data bytes per packet (1..255).
- BAUD_DIV, 16, clocks per serial bit (>=2).
- TIMEOUT, 1024, max clocks waiting for a byte mid-packet before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows a new packet to start (sampled in IDLE only).
- clear_err  in  1  synchronous clear of `error`.
- fifo_data_in  in  8  FIFO read data.
- fifo_empty  in  1  FIFO has no bytes.
- fifo_busy  in  1  FIFO port busy; no read may be issued.
- fifo_re  out  1  one-cycle read pulse.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.
- isFinish  out  1  one-cycle pulse after the CRC stop bit.
- CRC  out  8  running CRC; holds the final value after a packet.
- error  out  4  sticky: [0] underrun timeout, [1] enable dropped mid-packet, [3:2] always 0.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; tx=1; fifo_re=0; busy=0; isFinish=0; CRC=0; error=0; byte counter=0; baud counter=0.
- CRC-8 definition: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Bit update: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 0).
  - Updated once per data bit, at the end of that bit period.
  - CRC byte bits do not update it.
  - Cleared to 0 on the IDLE->FETCH transition.
- Frame format per byte:
  - 1 start bit (0), then 8 data bits MSB-first, then 1 stop bit (1).
  - Each bit is held exactly BAUD_DIV clocks, so a frame is 10*BAUD_DIV clocks.
- States:
  - IDLE: tx=1. If enable && !fifo_empty: clear CRC and the byte counter, go to FETCH.
  - FETCH: if !fifo_empty && !fifo_busy: fifo_re<=1 for exactly one cycle, go to WAIT.
    - Otherwise increment the timeout counter.
    - If the counter reaches TIMEOUT and the byte counter > 0: set error[0], go to IDLE with tx=1 (no CRC sent, no isFinish).
    - The timeout counter resets on entry to FETCH.
  - WAIT: fifo_re<=0. The FIFO presents data one cycle after seeing re. Go to LOAD.
  - LOAD: shift register <= fifo_data_in; go to START.
  - START: tx=0 for BAUD_DIV clocks, then DATA.
  - DATA: tx=shift[7] for BAUD_DIV clocks per bit.
    - At the end of each bit: update CRC (data bytes only), shift left.
    - After 8 bits, go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. Then:
    - if the CRC byte was just sent: go to DONE;
    - else increment the byte counter; if it equals PKT_LEN, go to CRCLD, else go to FETCH.
  - CRCLD: shift <= CRC; mark the crc phase; go to START.
  - DONE: isFinish=1 for one cycle, go to IDLE.
- `tx` is registered and glitch-free.
- Latency: the fifo_re pulse rises 1 clock after FETCH entry (when the FIFO is ready); the start bit begins 3 clocks after the fifo_re rise.
- enable low mid-packet: ignored for control (the packet completes), but sets error[1].
- fifo_empty rising mid-frame: no effect until the next FETCH.
- A new packet can start the cycle after DONE if enable && !fifo_empty.
- clear_err and a new error event in the same cycle: the event wins.
- Reset mid-frame: tx returns to 1 immediately (async); the partial frame is discarded.

Test Plan:
1. PKT_LEN=1, BAUD_DIV=4; FIFO holds 0x01; enable=1.
   -> tx carries frame 0,00000001,1, then CRC frame 0,00000111,1.
   -> CRC=0x07; isFinish pulses once, 80 clocks after the start bit.
2. PKT_LEN=2; bytes 0x01,0x02.
   -> exactly 2 fifo_re pulses; CRC=0x1B; third frame data=0x1B.
3. PKT_LEN=9; bytes ASCII "123456789" (0x31..0x39).
   -> CRC=0xF4; 10 frames; isFinish once.
4. PKT_LEN=4; FIFO goes empty after 2 bytes for TIMEOUT+5 clocks.
   -> error=4'b0001; no CRC frame; no isFinish; busy=0; tx=1.
5. fifo_busy held high 20 cycles while the FIFO is non-empty.
   -> no fifo_re during busy; the read issues the cycle after busy drops.
   -> enable dropped mid-packet: the packet still completes, error[1]=1; clear_err -> error=0.
6. reset asserted low during DATA bit 3.
   -> tx=1, busy=0, CRC=0 immediately.
   -> after release with enable=1, the next packet transmits correctly from the first byte.
